// File: rtl/spo256_allophone_sequencer.sv
// SPO256-AL2 allophone sequencer.
// Gathers allophone codes from the CPC decoder path and the ATmega into one shared
// FIFO. Each code is presented to the speech chip under its _LRQ/_ALD handshake,
// so neither requester has to watch _LRQ before writing.
`timescale 1ns/1ps

module spo256_allophone_sequencer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int ALD_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic                          iCLK,
  input  logic                          i_RESET,
  input  logic                          iCPC_WR,
  input  logic [7:0]                    iCPC_DATA,
  input  logic                          iMCU_WR,
  input  logic [7:0]                    iMCU_DATA,
  input  logic                          iCLR_STATUS,
  input  logic                          i_SPO256__LRQ,
  input  logic                          i_SPO256_SBY,
  output logic [5:0]                    oSPO256_ADR,
  output logic                          oSPO256__ALD,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
  output logic                          oFIFO_FULL,
  output logic                          oBUSY,
  output logic                          oOVERFLOW,
  output logic                          oTIMEOUT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_t;

  logic             lrq_meta, lrq_s;
  logic             sby_meta, sby_s;

  logic             hold_valid;
  logic [5:0]       hold_data;

  logic [5:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             fifo_full, fifo_empty;

  logic             push_req, push_ok, pop;
  logic [5:0]       push_data;
  logic             hold_load, hold_clear, mcu_drop;
  logic             overflow_evt, timeout_evt;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] ack_timer;
  logic [5:0]       spo_adr;
  logic             spo_ald;
  logic             overflow_flag, timeout_flag;

  // Only the low six bits of each byte carry an allophone address.
  logic             unused_data_bits;
  assign unused_data_bits = ^{iCPC_DATA[7:6], iMCU_DATA[7:6]};

  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);

  // Bring the asynchronous chip status pins into the clock domain; both idle high.
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      lrq_meta <= 1'b1;
      lrq_s    <= 1'b1;
      sby_meta <= 1'b1;
      sby_s    <= 1'b1;
    end else begin
      lrq_meta <= i_SPO256__LRQ;
      lrq_s    <= lrq_meta;
      sby_meta <= i_SPO256_SBY;
      sby_s    <= sby_meta;
    end
  end

  // Enqueue arbitration: CPC wins, a colliding MCU write waits one clock in the hold register.
  always_comb begin
    push_req   = 1'b0;
    push_data  = 6'd0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    mcu_drop   = 1'b0;
    if (iCPC_WR) begin
      push_req  = 1'b1;
      push_data = iCPC_DATA[5:0];
      if (iMCU_WR) begin
        if (hold_valid) mcu_drop  = 1'b1;
        else            hold_load = 1'b1;
      end
    end else if (hold_valid) begin
      push_req   = 1'b1;
      push_data  = hold_data;
      hold_clear = 1'b1;
      if (iMCU_WR) hold_load = 1'b1;
    end else if (iMCU_WR) begin
      push_req  = 1'b1;
      push_data = iMCU_DATA[5:0];
    end
  end

  // A pop frees a slot in the same clock, so a full FIFO still accepts a push then.
  assign pop          = (state == IDLE) && !fifo_empty && !lrq_s;
  assign push_ok      = push_req && (!fifo_full || pop);
  assign overflow_evt = (push_req && !push_ok) || mcu_drop;
  assign timeout_evt  = (state == ACK) && !lrq_s && (ack_timer == CNT_W'(ACK_TIMEOUT));

  // Hold register for an MCU byte that lost arbitration to the CPC.
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      hold_valid <= 1'b0;
      hold_data  <= 6'd0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_data  <= iMCU_DATA[5:0];
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because the level says what is valid.
  always_ff @(posedge iCLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Handshake sequencer: present the address, pulse _ALD, then wait for _LRQ to rise.
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state     <= IDLE;
      spo_adr   <= 6'd0;
      spo_ald   <= 1'b1;
      phase_cnt <= '0;
      ack_timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            spo_adr   <= mem[rd_ptr];
            phase_cnt <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            phase_cnt <= '0;
            spo_ald   <= 1'b0;
            state     <= STROBE;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        STROBE: begin
          if (phase_cnt == CNT_W'(ALD_CYCLES - 1)) begin
            phase_cnt <= '0;
            spo_ald   <= 1'b1;
            ack_timer <= '0;
            state     <= ACK;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        ACK: begin
          if (lrq_s || timeout_evt) state <= IDLE;
          else                      ack_timer <= ack_timer + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a fresh error in the same clock as a clear keeps the flag set.
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      overflow_flag <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      if (overflow_evt)     overflow_flag <= 1'b1;
      else if (iCLR_STATUS) overflow_flag <= 1'b0;
      if (timeout_evt)      timeout_flag  <= 1'b1;
      else if (iCLR_STATUS) timeout_flag  <= 1'b0;
    end
  end

  assign oSPO256_ADR  = spo_adr;
  assign oSPO256__ALD = spo_ald;
  assign oFIFO_LEVEL  = level;
  assign oFIFO_FULL   = fifo_full;
  assign oBUSY        = !fifo_empty || (state != IDLE) || !sby_s;
  assign oOVERFLOW    = overflow_flag;
  assign oTIMEOUT     = timeout_flag;

endmodule
